traffic_timer: RTL and testbench

Interval timer stage feeding the traffic-light FSM. Holds the programmable time-parameter table, and on each `start_timer` pulse from the FSM loads the duration selected by `interval`. It then counts whole seconds from an internal one-second tick and pulses `expired` back to the FSM when the duration elapses. It also handles reprogramming of the table from the synchronized program inputs.

---
 rtl/traffic_pkg.sv | 37 +++
 rtl/one_hz_enable.sv | 30 +++
 rtl/traffic_timer.sv | 120 ++++++++++++
 tb/tb_traffic_timer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light interval timer: interval codes,
// timer state encoding, default time parameters and the table selector width.
package traffic_pkg;

    localparam int SEL_W  = 2;
    localparam int CODE_W = 3;

    localparam logic [CODE_W-1:0] INT_BASE = 3'd0;
    localparam logic [CODE_W-1:0] INT_EXT  = 3'd1;
    localparam logic [CODE_W-1:0] INT_YEL  = 3'd2;
    localparam logic [CODE_W-1:0] INT_WALK = 3'd3;

    localparam int DFLT_BASE = 6;
    localparam int DFLT_EXT  = 3;
    localparam int DFLT_YEL  = 2;
    localparam int DFLT_WALK = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } timer_state_t;

    // Reserved interval codes fall back to the BASE entry.
    function automatic logic [SEL_W-1:0] entry_of(input logic [CODE_W-1:0] code);
        logic [SEL_W-1:0] idx;
        case (code)
            INT_BASE: idx = 2'd0;
            INT_EXT:  idx = 2'd1;
            INT_YEL:  idx = 2'd2;
            INT_WALK: idx = 2'd3;
            default:  idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/one_hz_enable.sv
// Tick divider: counts 0..TICK_CYCLES-1 and flags the terminal count as a
// one-cycle tick. A synchronous clear restarts the phase.
module one_hz_enable #(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic Reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    // Free-running divider, restarted on reset or clear.
    always_ff @(posedge clk) begin
        if (Reset || clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == LAST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/traffic_timer.sv
// Interval timer for the traffic-light FSM: programmable time-parameter table,
// whole-second countdown and a one-cycle expiry pulse.
module traffic_timer
    import traffic_pkg::*;
#(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int VAL_W       = 4,
    parameter int DEF_BASE    = DFLT_BASE,
    parameter int DEF_EXT     = DFLT_EXT,
    parameter int DEF_YEL     = DFLT_YEL,
    parameter int DEF_WALK    = DFLT_WALK
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               start_timer,
    input  logic [CODE_W-1:0]  interval,
    input  logic               Prog_Sync,
    input  logic [SEL_W-1:0]   Time_Param_Sel,
    input  logic [VAL_W-1:0]   Time_Value,
    output logic               expired,
    output logic               running
);

    logic [VAL_W-1:0] tbl_r [4];
    logic [VAL_W-1:0] remaining_r;
    logic [VAL_W-1:0] sel_val_s;
    logic [VAL_W-1:0] load_val_s;
    timer_state_t     state_r;
    logic             expired_r;
    logic             running_r;
    logic             start_s;
    logic             tick_s;

    // A reprogram cycle swallows any start issued alongside it.
    assign start_s = start_timer & ~Prog_Sync;

    one_hz_enable #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk   (clk),
        .Reset (Reset),
        .clear (start_s),
        .tick  (tick_s)
    );

    // Selected duration, with zero promoted to one second.
    always_comb begin
        sel_val_s = tbl_r[entry_of(interval)];
        if (sel_val_s == {VAL_W{1'b0}}) begin
            load_val_s = VAL_W'(1);
        end else begin
            load_val_s = sel_val_s;
        end
    end

    // Time-parameter table with reset defaults.
    always_ff @(posedge clk) begin
        if (Reset) begin
            tbl_r[0] <= VAL_W'(DEF_BASE);
            tbl_r[1] <= VAL_W'(DEF_EXT);
            tbl_r[2] <= VAL_W'(DEF_YEL);
            tbl_r[3] <= VAL_W'(DEF_WALK);
        end else if (Prog_Sync) begin
            tbl_r[Time_Param_Sel] <= Time_Value;
        end
    end

    // Timer state machine; restart and abort win over a coincident terminal tick.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r     <= IDLE;
            remaining_r <= {VAL_W{1'b0}};
            expired_r   <= 1'b0;
            running_r   <= 1'b0;
        end else if (Prog_Sync) begin
            state_r   <= IDLE;
            expired_r <= 1'b0;
            running_r <= 1'b0;
        end else if (start_s) begin
            state_r     <= COUNT;
            remaining_r <= load_val_s;
            expired_r   <= 1'b0;
            running_r   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    expired_r <= 1'b0;
                    running_r <= 1'b0;
                end
                COUNT: begin
                    expired_r <= 1'b0;
                    if (tick_s) begin
                        if (remaining_r <= VAL_W'(1)) begin
                            state_r     <= DONE;
                            remaining_r <= {VAL_W{1'b0}};
                            expired_r   <= 1'b1;
                            running_r   <= 1'b0;
                        end else begin
                            remaining_r <= remaining_r - VAL_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_r   <= IDLE;
                    expired_r <= 1'b0;
                    running_r <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    expired_r <= 1'b0;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    assign expired = expired_r;
    assign running = running_r;

endmodule

// File: tb/tb_traffic_timer.sv
// Bench for traffic_timer: directed scenarios plus random traffic, checked every
// cycle against a deadline-based reference model.
module tb_traffic_timer;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start_timer = 1'b0;
    logic [2:0] interval = 3'd0;
    logic       Prog_Sync = 1'b0;
    logic [1:0] Time_Param_Sel = 2'd0;
    logic [3:0] Time_Value = 4'd0;
    logic       expired;
    logic       running;

    int checks = 0;
    int errors = 0;

    // Reference model: table contents plus the absolute edge of the next expiry.
    int  m_tbl [4];
    bit  m_active = 1'b0;
    int  m_target = 0;
    bit  m_expired = 1'b0;
    int  edge_no = 0;

    traffic_timer #(
        .TICK_CYCLES(T),
        .VAL_W(4)
    ) dut (
        .clk            (clk),
        .Reset          (Reset),
        .start_timer    (start_timer),
        .interval       (interval),
        .Prog_Sync      (Prog_Sync),
        .Time_Param_Sel (Time_Param_Sel),
        .Time_Value     (Time_Value),
        .expired        (expired),
        .running        (running)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_no, obs, exp_v);
        end
    endtask

    task automatic model_update(input bit rst, input bit st, input int iv,
                                input bit pg, input int ps, input int tv);
        int idx;
        int d;
        if (rst) begin
            m_tbl[0] = 6; m_tbl[1] = 3; m_tbl[2] = 2; m_tbl[3] = 3;
            m_active = 1'b0;
            m_expired = 1'b0;
        end else if (pg) begin
            m_tbl[ps] = tv;
            m_active = 1'b0;
            m_expired = 1'b0;
        end else if (st) begin
            idx = (iv > 3) ? 0 : iv;
            d = (m_tbl[idx] == 0) ? 1 : m_tbl[idx];
            m_target = edge_no + d * T;
            m_active = 1'b1;
            m_expired = 1'b0;
        end else if (m_active && edge_no == m_target) begin
            m_active = 1'b0;
            m_expired = 1'b1;
        end else begin
            m_expired = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model and compare.
    task automatic step(input bit rst, input bit st, input int iv,
                        input bit pg, input int ps, input int tv);
        Reset          = rst;
        start_timer    = st;
        interval       = 3'(iv);
        Prog_Sync      = pg;
        Time_Param_Sel = 2'(ps);
        Time_Value     = 4'(tv);
        @(posedge clk);
        edge_no++;
        model_update(rst, st, iv, pg, ps, tv);
        #1;
        check_val("expired", int'(expired), int'(m_expired));
        check_val("running", int'(running), int'(m_active));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic start(input int iv);
        step(1'b0, 1'b1, iv, 1'b0, 0, 0);
    endtask

    task automatic prog(input int ps, input int tv);
        step(1'b0, 1'b0, 0, 1'b1, ps, tv);
    endtask

    initial begin
        int r;
        @(negedge clk);
        step(1'b1, 1'b0, 0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 1'b0, 0, 0);
        idle(7);
        // BASE count, 24 cycles
        start(0);
        idle(30);
        // reprogram YEL, use it, then reset restores default
        prog(2, 5);
        start(2);
        idle(24);
        step(1'b1, 1'b0, 0, 1'b0, 0, 0);
        start(2);
        idle(10);
        // retrigger mid-count
        start(0);
        idle(19);
        start(1);
        idle(15);
        // reserved code behaves as BASE
        start(6);
        idle(26);
        // zero duration counts as one second, then abort by reprogram
        prog(3, 0);
        start(3);
        idle(6);
        start(0);
        idle(5);
        prog(3, 3);
        idle(3);
        // retrigger on the terminal edge suppresses the pending expiry
        start(0);
        idle(23);
        start(1);
        idle(16);
        // start coincident with reprogram is ignored
        step(1'b0, 1'b1, 0, 1'b1, 1, 2);
        idle(4);
        // reset mid-count
        start(0);
        idle(9);
        step(1'b1, 1'b0, 0, 1'b0, 0, 0);
        idle(30);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 299));
            if (r == 0)
                step(1'b1, 1'($urandom_range(0, 1)), 0, 1'b0, 0, 0);
            else if (r < 6)
                step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'b1,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
            else if (r < 16)
                step(1'b0, 1'b1, int'($urandom_range(0, 7)), 1'b0, 0, 0);
            else
                idle(1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
